priority_scan_encoder: RTL and testbench
========================================

// Module: priority_scan_encoder
// PURPOSE
//   Parametrised, handshaked successor to the 8:3 combinational priority encoder.
//   - Latches a WIDTH-bit request vector.
//   - Emits the index of every set bit, one per output beat, in priority order.
//   - Default priority is highest index first. LSB_FIRST=1 reverses it to lowest index first.
//   - Sits between a request source and a consumer that services one index at a time.
//   - Valid/ready on both sides.
// PARAMETERS
//   WIDTH      8                  request vector width; must be >= 2
//   LSB_FIRST  0                  0: highest set index served first; 1: lowest set index first
//   IDX_W      $clog2(WIDTH)      index width (derived localparam, not overridable)
// PORTS
//   clk        in   1      single clock; all logic on rising edge
//   rst        in   1      synchronous, active-high reset
//   in_valid   in   1      in_vec is valid
//   in_ready   out  1      block can accept a vector (high only in IDLE)
//   in_vec     in   WIDTH  request vector
//   out_valid  out  1      out_idx/out_last/out_none are valid
//   out_ready  in   1      consumer accepts the current beat
//   out_idx    out  IDX_W  index of the current highest-priority pending bit
//   out_last   out  1      current beat is the final beat for this vector
//   out_none   out  1      latched vector was all-zero (single beat, out_idx=0)
//   busy       out  1      high in SCAN state
// BEHAVIOUR
//   Reset and clocking
//   - One clock. Reset is synchronous and active-high: rst sampled high on a rising clk
//     edge forces the reset state at that edge.
//   - Reset values: state=IDLE, pend=0, out_valid=0, out_idx=0, out_last=0,
//     out_none=0, busy=0.
//   - in_ready=1 from the first cycle after reset release.
//   - rst wins over every other event. A vector offered while rst=1 is not accepted.
//   FSM
//   - IDLE: in_ready=1, out_valid=0. On in_valid&&in_ready, pend<=in_vec,
//     none<=(in_vec==0), state<=SCAN.
//   - SCAN: in_ready=0, out_valid=1, busy=1.
//     - out_idx = priority index of pend (per LSB_FIRST).
//     - out_last = 1 when pend has <=1 bit set.
//     - out_none = none flag.
//     - On out_valid&&out_ready: clear bit out_idx in pend. If out_last, state<=IDLE.
//   Timing and throughput
//   - Latency: vector accepted at edge N, first beat valid in cycle N+1.
//   - No combinational path from in_* or out_ready to any out_* signal. All outputs
//     decode from registers only.
//   - A vector with K set bits (K>=1) takes K beats. A zero vector takes 1 beat.
//     IDLE lasts >=1 cycle between vectors.
//   - Backpressure: while out_valid&&!out_ready, out_idx, out_last and out_none hold stable.
//   Boundary conditions
//   - Zero vector: one beat with out_idx=0, out_none=1, out_last=1. The first-beat
//     index matches the legacy 8:3 encoder's 000 output.
//   - All-ones vector: WIDTH beats. Only the final one asserts out_last.
//   - Index WIDTH-1 and index 0 are both reachable. Non-power-of-two WIDTH never
//     produces out_idx >= WIDTH.
//   - in_valid while busy is ignored (in_ready=0). The source must hold it until accepted.
//   - Reset mid-scan: remaining bits are discarded and no further beats are emitted.
//     out_valid=0 the cycle after the reset edge.
// TESTING
//   1. Assert rst 2 cycles -> out_valid=0, busy=0; after release in_ready=1.
//   2. W=8, in_vec=8'b1010_0110, out_ready=1 -> out_idx 7,5,2,1 on consecutive
//      cycles, out_last only on 1; in_ready=1 on the next cycle.
//   3. in_vec=8'h00 -> single beat out_idx=0, out_none=1, out_last=1.
//   4. in_vec=8'h81, out_ready=0 for 3 cycles -> out_idx=7 held stable; then out_ready=1
//      -> 7, then 0 with out_last.
//   5. LSB_FIRST=1, in_vec=8'b1010_0110 -> out_idx 1,2,5,7. Separately, W=16 and
//      in_vec=16'h8001 -> 15,0.
//   6. in_vec=8'hFF, rst after the first beat -> out_valid=0 next cycle. Then in_vec=8'h10
//      -> one beat out_idx=4, out_last=1.
//      Also sweep all 256 8-bit vectors: first out_idx must equal the legacy 8:3 encoder output.

Source files
------------

// File: rtl/priority_scan_encoder_if.sv
// Valid/ready bundle for priority_scan_encoder.
// in_*: request vector from source; out_*: index beats to consumer.
interface priority_scan_encoder_if #(
    parameter int WIDTH = 8
);
    localparam int IDX_W = $clog2(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_vec;
    logic             out_valid;
    logic             out_ready;
    logic [IDX_W-1:0] out_idx;
    logic             out_last;
    logic             out_none;

    modport master (
        output in_valid, in_vec, out_ready,
        input  in_ready, out_valid, out_idx,
        input  out_last, out_none
    );

    modport slave (
        input  in_valid, in_vec, out_ready,
        output in_ready, out_valid, out_idx,
        output out_last, out_none
    );
endinterface

// File: rtl/priority_scan_encoder.sv
// Latches a request vector and emits one set-bit index per beat.
// Ports: clk, rst (sync, high), bus (slave handshake), busy (SCAN).
module priority_scan_encoder #(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst,
    priority_scan_encoder_if.slave   bus,
    output logic                     busy
);
    localparam int IDX_W = $clog2(WIDTH);

    typedef enum logic {
        IDLE,
        SCAN
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pend_q, pend_d;
    logic             none_q, none_d;

    logic [IDX_W-1:0] pri_idx;
    logic             multi;
    logic             scan;
    logic             last;

    // Later hits overwrite earlier ones, so the
    // loop direction selects the winning end.
    always_comb begin
        pri_idx = '0;
        if (LSB_FIRST) begin
            for (int i = WIDTH - 1; i >= 0; i--) begin
                if (pend_q[i]) pri_idx = IDX_W'(i);
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (pend_q[i]) pri_idx = IDX_W'(i);
            end
        end
    end

    // More than one bit set: clearing the lowest
    // set bit still leaves something behind.
    assign multi = (pend_q & (pend_q - WIDTH'(1))) != '0;
    assign scan  = (state_q == SCAN);
    assign last  = scan && !multi;

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        none_d  = none_q;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    pend_d  = bus.in_vec;
                    none_d  = (bus.in_vec == '0);
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (bus.out_ready) begin
                    pend_d = pend_q & ~(WIDTH'(1) << pri_idx);
                    if (last) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pend_q  <= '0;
            none_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            none_q  <= none_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = scan;
    assign bus.out_idx   = scan ? pri_idx : '0;
    assign bus.out_last  = last;
    assign bus.out_none  = scan && none_q;
    assign busy          = scan;
endmodule

// File: tb/tb_priority_scan_encoder.sv
// Bench: three encoder instances run in lockstep
// (W8 msb-first, W8 lsb-first, W16 msb-first).
module tb_priority_scan_encoder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  vec8 = '0;
    logic [15:0] vec16 = '0;
    logic        out_ready = 1'b1;
    logic        busy_m8, busy_l8, busy_16;

    int checks = 0;
    int failures = 0;
    int stall_left = 0;
    int beat_cnt = 0;
    int first_idx = 0;
    bit mon_en = 1'b0;

    typedef struct {
        logic [3:0] idx;
        logic       last;
        logic       none;
    } sb_t;

    sb_t q_m8[$];
    sb_t q_l8[$];
    sb_t q_16[$];

    typedef struct {
        logic [7:0]  v8;
        logic [15:0] v16;
        int          stall;
        int          exp_first;
        int          exp_beats;
    } vec_t;

    vec_t tbl[8];

    always #5 clk = ~clk;

    priority_scan_encoder_if #(.WIDTH(8))  if_m8 ();
    priority_scan_encoder_if #(.WIDTH(8))  if_l8 ();
    priority_scan_encoder_if #(.WIDTH(16)) if_16 ();

    assign if_m8.in_valid  = in_valid;
    assign if_m8.in_vec    = vec8;
    assign if_m8.out_ready = out_ready;
    assign if_l8.in_valid  = in_valid;
    assign if_l8.in_vec    = vec8;
    assign if_l8.out_ready = out_ready;
    assign if_16.in_valid  = in_valid;
    assign if_16.in_vec    = vec16;
    assign if_16.out_ready = out_ready;

    priority_scan_encoder #(.WIDTH(8), .LSB_FIRST(1'b0)) u_m8 (
        .clk  (clk),
        .rst  (rst),
        .bus  (if_m8.slave),
        .busy (busy_m8)
    );

    priority_scan_encoder #(.WIDTH(8), .LSB_FIRST(1'b1)) u_l8 (
        .clk  (clk),
        .rst  (rst),
        .bus  (if_l8.slave),
        .busy (busy_l8)
    );

    priority_scan_encoder #(.WIDTH(16), .LSB_FIRST(1'b0)) u_16 (
        .clk  (clk),
        .rst  (rst),
        .bus  (if_16.slave),
        .busy (busy_16)
    );

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d required=%0d", name, got, exp);
        end
    endtask

    function automatic int legacy8(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) return i;
        end
        return 0;
    endfunction

    task automatic push(input int which, input sb_t e);
        case (which)
            0: q_m8.push_back(e);
            1: q_l8.push_back(e);
            default: q_16.push_back(e);
        endcase
    endtask

    task automatic expect_beats(input logic [15:0] v, input int w,
                                input bit lsb, input int which);
        sb_t e;
        int  n;
        int  seen;
        int  i;
        n = 0;
        for (int k = 0; k < w; k++) if (v[k]) n++;
        if (n == 0) begin
            e.idx = 4'd0;
            e.last = 1'b1;
            e.none = 1'b1;
            push(which, e);
            return;
        end
        seen = 0;
        for (int k = 0; k < w; k++) begin
            i = lsb ? k : (w - 1 - k);
            if (v[i]) begin
                seen++;
                e.idx = 4'(i);
                e.last = (seen == n);
                e.none = 1'b0;
                push(which, e);
            end
        end
    endtask

    task automatic chk_beat(input int which, input logic v,
                            input logic [3:0] idx, input logic last,
                            input logic none, input bit pop);
        sb_t e;
        int  sz;
        if (!v) return;
        case (which)
            0: sz = q_m8.size();
            1: sz = q_l8.size();
            default: sz = q_16.size();
        endcase
        checks++;
        if (sz == 0) begin
            failures++;
            $display("FAIL spurious_beat inst=%0d got idx=%0d required no beat",
                     which, idx);
            return;
        end
        case (which)
            0: e = q_m8[0];
            1: e = q_l8[0];
            default: e = q_16[0];
        endcase
        if ({idx, last, none} !== {e.idx, e.last, e.none}) begin
            failures++;
            $display("FAIL beat inst=%0d got idx=%0d last=%0b none=%0b required idx=%0d last=%0b none=%0b",
                     which, idx, last, none, e.idx, e.last, e.none);
        end
        if (pop) begin
            case (which)
                0: void'(q_m8.pop_front());
                1: void'(q_l8.pop_front());
                default: void'(q_16.pop_front());
            endcase
        end
    endtask

    // Monitor: decides backpressure, then checks each valid beat
    // against the head of its queue; stalled beats are re-checked
    // every cycle so they must hold stable.
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            if (if_m8.out_valid && stall_left > 0) begin
                out_ready = 1'b0;
                stall_left--;
            end else begin
                out_ready = 1'b1;
            end
            if (if_m8.out_valid && out_ready) begin
                if (beat_cnt == 0) first_idx = int'(if_m8.out_idx);
                beat_cnt++;
            end
            chk_beat(0, if_m8.out_valid, {1'b0, if_m8.out_idx},
                     if_m8.out_last, if_m8.out_none, out_ready);
            chk_beat(1, if_l8.out_valid, {1'b0, if_l8.out_idx},
                     if_l8.out_last, if_l8.out_none, out_ready);
            chk_beat(2, if_16.out_valid, if_16.out_idx,
                     if_16.out_last, if_16.out_none, out_ready);
            chk("in_ready_vs_valid", int'(if_m8.in_ready),
                int'(!if_m8.out_valid));
            chk("busy_vs_valid", int'(busy_m8), int'(if_m8.out_valid));
        end
    end

    function automatic bit all_ready();
        return if_m8.in_ready && if_l8.in_ready && if_16.in_ready;
    endfunction

    function automatic bit all_empty();
        return q_m8.size() == 0 && q_l8.size() == 0 && q_16.size() == 0;
    endfunction

    task automatic flush();
        q_m8.delete();
        q_l8.delete();
        q_16.delete();
    endtask

    task automatic send(input logic [7:0] v8, input logic [15:0] v16,
                        input int stall);
        int t;
        t = 0;
        while (!all_ready() && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) begin
            checks++;
            failures++;
            $display("FAIL in_ready_timeout got=0 required=1");
        end
        expect_beats({8'h00, v8}, 8, 1'b0, 0);
        expect_beats({8'h00, v8}, 8, 1'b1, 1);
        expect_beats(v16, 16, 1'b0, 2);
        beat_cnt = 0;
        stall_left = stall;
        in_valid = 1'b1;
        vec8 = v8;
        vec16 = v16;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (!all_empty() && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout got=%0d required=0",
                     q_m8.size());
            flush();
        end
    endtask

    initial begin
        tbl[0] = '{8'b1010_0110, 16'h5A00, 0, 7, 4};
        tbl[1] = '{8'h00, 16'h0000, 0, 0, 1};
        tbl[2] = '{8'h81, 16'h8001, 3, 7, 2};
        tbl[3] = '{8'hFF, 16'hFF00, 0, 7, 8};
        tbl[4] = '{8'h01, 16'h8000, 0, 0, 1};
        tbl[5] = '{8'h80, 16'h0001, 1, 7, 1};
        tbl[6] = '{8'h10, 16'h0400, 0, 4, 1};
        tbl[7] = '{8'h3C, 16'h0F00, 2, 5, 4};

        // Reset with a vector offered: it must not be taken.
        rst = 1'b1;
        in_valid = 1'b1;
        vec8 = 8'h81;
        vec16 = 16'h8001;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", int'(if_m8.out_valid), 0);
        chk("rst_busy", int'(busy_m8 | busy_l8 | busy_16), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", int'(all_ready()), 1);
        chk("post_rst_out_valid",
            int'(if_m8.out_valid | if_l8.out_valid | if_16.out_valid), 0);
        chk("post_rst_idx", int'(if_m8.out_idx), 0);
        chk("post_rst_last", int'(if_m8.out_last), 0);
        chk("post_rst_none", int'(if_m8.out_none), 0);
        mon_en = 1'b1;

        for (int n = 0; n < 8; n++) begin
            send(tbl[n].v8, tbl[n].v16, tbl[n].stall);
            drain();
            chk("tbl_first_idx", first_idx, tbl[n].exp_first);
            chk("tbl_beats", beat_cnt, tbl[n].exp_beats);
        end

        // Reset after the first beat of an all-ones scan.
        send(8'hFF, 16'hFF00, 0);
        begin
            int t;
            t = 0;
            while (beat_cnt < 1 && t < 20) begin
                @(negedge clk);
                t++;
            end
            chk("midscan_first_beat", int'(beat_cnt >= 1), 1);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        flush();
        @(negedge clk);
        chk("midscan_rst_valid",
            int'(if_m8.out_valid | if_l8.out_valid | if_16.out_valid), 0);
        chk("midscan_rst_busy", int'(busy_m8), 0);
        send(8'h10, 16'h0400, 0);
        drain();
        chk("after_rst_first", first_idx, 4);
        chk("after_rst_beats", beat_cnt, 1);

        // Every 8-bit vector: first beat matches the legacy encoder.
        for (int v = 0; v < 256; v++) begin
            send(8'(v), {8'(v), 8'h00}, 0);
            drain();
            chk("legacy_first", first_idx, legacy8(8'(v)));
        end

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout required=finish");
        $fatal(1, "watchdog");
    end
endmodule
